if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the miniLA single-cycle core. It sits directly upstream of the decode controller, which consumes inst[31:15].
- Owns the PC register. Fetches from instruction ROM over a req/ack handshake and presents one instruction at a time to decode/execute with a valid/ready handshake.
- When decode accepts an instruction, it computes the next PC from that same cycle's npc_op, pc_sel, br_flag, rd1 and offset.
- Detects misaligned fetch targets and keeps a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset (must be word-aligned).
- XLEN, 32, address/data width.

Ports:
- cpu_clk  in  1  system clock, rising edge.
- cpu_rst  in  1  synchronous active-high reset.
- irom_req  out  1  fetch request to instruction ROM.
- irom_addr  out  XLEN  fetch byte address; equals pc.
- irom_ack  in  1  ROM has valid irom_rdata this cycle; may be combinational on irom_req.
- irom_rdata  in  XLEN  fetched instruction word.
- inst  out  XLEN  buffered instruction to decode.
- inst_valid  out  1  inst/pc/pc4 are valid.
- inst_ready  in  1  decode/execute accepts the instruction this cycle; low means stall.
- pc  out  XLEN  address of inst.
- pc4  out  XLEN  pc+4, used as link value for BL/JIRL.
- npc_op  in  2  from controller: 0 PC4, 1 BRC, 2 JMP, 3 PC4_ADD.
- pc_sel  in  1  jump base: 0 = pc, 1 = rd1 (JIRL).
- br_flag  in  1  ALU branch-condition result.
- rd1  in  XLEN  register-file read port 1.
- offset  in  XLEN  sign-extended branch/jump offset, already shifted.
- fetch_err  out  1  sticky misaligned-target error.
- inst_cnt  out  XLEN  count of accepted instructions.

Behaviour:
- States: BOOT, REQ, VALID, ERR. Encoding is 2-bit, taken from the package.
- Reset, while cpu_rst is high at an edge:
  - state=BOOT, pc=RESET_PC, inst=0, inst_cnt=0, fetch_err=0.
  - Outputs in BOOT: irom_req=0, inst_valid=0.
  - An irom_ack arriving in the reset cycle is ignored.
- BOOT: unconditionally go to REQ on the next cycle.
- REQ:
  - irom_req=1 and irom_addr=pc, both held stable until ack.
  - On irom_ack: inst<=irom_rdata, go to VALID. irom_rdata is sampled only when ack is high.
- VALID:
  - inst_valid=1, irom_req=0. inst, pc and pc4 stay stable while inst_ready=0.
  - On inst_ready: compute npc, inst_cnt<=inst_cnt+1 (wraps mod 2^32).
    - If npc[1:0]==0: pc<=npc, go to REQ.
    - Otherwise: fetch_err<=1, go to ERR; pc is unchanged.
- npc rules:
  - PC4 (0): pc+4.
  - BRC (1): br_flag ? pc+offset : pc+4.
  - JMP (2): (pc_sel ? rd1 : pc)+offset.
  - PC4_ADD (3): pc+4. PCADDU's pc+offset result is produced by the ALU path, not here.
  - All adds are modulo 2^32, so 32'hFFFF_FFFC+4 = 0.
  - pc_sel is ignored unless npc_op=JMP.
- ERR: irom_req=0, inst_valid=0, fetch_err=1. Leaves only on reset.
- Throughput: 2 cycles per instruction minimum (REQ with same-cycle ack, then VALID with ready). Each extra ROM wait cycle or stall cycle adds 1.
- Only one outstanding request at a time, so no speculation and no flush logic are needed.
- Reset mid-fetch (in REQ) or mid-stall (in VALID): the pending request and instruction are abandoned, inst_cnt is not incremented, and fetch restarts at RESET_PC after BOOT.
- inst_ready is ignored outside VALID. irom_ack is ignored outside REQ.
- pc4 is combinational pc+4 and is valid whenever inst_valid=1.

Decomposition:
- Package miniLA_pkg holds:
  - NPC_PC4/BRC/JMP/PC4_ADD = 0/1/2/3 (shared with the controller).
  - Fetch state encoding BOOT/REQ/VALID/ERR.
  - XLEN default.
- Sub-module npc_calc: purely combinational. Inputs pc, npc_op, pc_sel, br_flag, rd1, offset. Outputs npc and misalign.
- The FSM, PC register, instruction buffer and counter live in if_fetch_unit.

Test Plan:
- Reset then release, ROM acks combinationally with 32'h0280_0401:
  - BOOT shows irom_req=0.
  - Next cycle irom_req=1, irom_addr=0.
  - Next cycle inst_valid=1, inst=32'h0280_0401, pc=0, pc4=4.
- Sequential stream, inst_ready=1, npc_op=0, ack after 2 wait cycles: irom_addr sequence 0,4,8; 4 cycles per inst; inst_cnt=3 after the third accept.
- At pc=32'h100, npc_op=1, offset=32'hFFFF_FFF0:
  - br_flag=1 → next irom_addr=32'hF0.
  - br_flag=0 → next irom_addr=32'h104.
- At pc=32'h40, npc_op=2, pc_sel=1, rd1=32'h2000, offset=8 → next irom_addr=32'h2008, and pc4 was 32'h44 during accept.
- JIRL with rd1=32'h2002, offset=0:
  - fetch_err=1 and irom_req=0 from the next cycle; inst_cnt is incremented.
  - Stays in ERR for 10 cycles; after reset, fetch_err=0 and pc=RESET_PC.
- Stall then reset:
  - Hold inst_ready=0 for 5 cycles in VALID → inst and pc stable, no irom_req.
  - Assert cpu_rst during REQ with irom_ack=1 → ack ignored, inst=0, state BOOT.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared miniLA encodings for next-PC selection and fetch sequencing
// Contents:
//   XLEN_DEFAULT  - default address/data width
//   npc_op_e      - next-PC operation from the controller (PC4/BRC/JMP/PC4_ADD)
//   fetch_state_e - fetch FSM state encoding (BOOT/REQ/VALID/ERR)
package miniLA_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        NPC_PC4     = 2'd0,
        NPC_BRC     = 2'd1,
        NPC_JMP     = 2'd2,
        NPC_PC4_ADD = 2'd3
    } npc_op_e;

    typedef enum logic [1:0] {
        F_BOOT  = 2'd0,
        F_REQ   = 2'd1,
        F_VALID = 2'd2,
        F_ERR   = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-ROM and decode-side handshake bundle of the fetch stage
// Signals:
//   irom_req/irom_addr       fetch request and byte address (fetch -> ROM)
//   irom_ack/irom_rdata      ROM response (ROM -> fetch)
//   inst/inst_valid/pc/pc4   buffered instruction to decode (fetch -> decode)
//   inst_ready               decode accepts the instruction (decode -> fetch)
//   npc_op/pc_sel/br_flag/rd1/offset  next-PC controls (core -> fetch)
// Modports: master = fetch unit, slave = ROM plus decode/execute
interface if_fetch_unit_if #(
    parameter int XLEN = miniLA_pkg::XLEN_DEFAULT
);

    logic            irom_req;
    logic [XLEN-1:0] irom_addr;
    logic            irom_ack;
    logic [XLEN-1:0] irom_rdata;
    logic [XLEN-1:0] inst;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [1:0]      npc_op;
    logic            pc_sel;
    logic            br_flag;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] offset;

    modport master (
        output irom_req, irom_addr, inst, inst_valid, pc, pc4,
        input  irom_ack, irom_rdata, inst_ready, npc_op, pc_sel, br_flag, rd1, offset
    );

    modport slave (
        input  irom_req, irom_addr, inst, inst_valid, pc, pc4,
        output irom_ack, irom_rdata, inst_ready, npc_op, pc_sel, br_flag, rd1, offset
    );

endinterface

// File: rtl/if_fetch_unit_npc_calc.sv
// npc_calc: combinational next-PC selection and word-alignment check
// Ports:
//   i_pc       current pc
//   i_npc_op   next-PC operation
//   i_pc_sel   jump base select (0 = pc, 1 = rd1), only meaningful for JMP
//   i_br_flag  branch condition result
//   i_rd1      register-file read port 1
//   i_offset   sign-extended, pre-shifted offset
//   o_npc      next pc
//   o_misalign next pc is not word-aligned
module npc_calc
    import miniLA_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] i_pc,
    input  npc_op_e         i_npc_op,
    input  logic            i_pc_sel,
    input  logic            i_br_flag,
    input  logic [XLEN-1:0] i_rd1,
    input  logic [XLEN-1:0] i_offset,
    output logic [XLEN-1:0] o_npc,
    output logic            o_misalign
);

    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_base;
    logic            w_add_off;

    // PC4_ADD deliberately falls through to pc+4; the pc+offset result of PCADDU comes from the ALU
    always_comb begin
        w_pc4      = i_pc + XLEN'(4);
        w_base     = (i_npc_op == NPC_JMP && i_pc_sel) ? i_rd1 : i_pc;
        w_add_off  = (i_npc_op == NPC_JMP) || (i_npc_op == NPC_BRC && i_br_flag);
        o_npc      = w_add_off ? w_base + i_offset : w_pc4;
        o_misalign = |o_npc[1:0];
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: miniLA fetch stage owning the PC, one-deep instruction buffer and retire counter
// Ports:
//   cpu_clk    system clock, rising edge
//   cpu_rst    synchronous active-high reset
//   bus        fetch-side handshake bundle (ROM request/response, decode valid/ready, next-PC controls)
//   fetch_err  sticky misaligned-target error
//   inst_cnt   count of instructions accepted by decode, wraps
module if_fetch_unit
    import miniLA_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    if_fetch_unit_if.master    bus,
    output logic               fetch_err,
    output logic [XLEN-1:0]    inst_cnt
);

    fetch_state_e    r_state;
    fetch_state_e    w_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_cnt;
    logic            r_err;
    logic [XLEN-1:0] w_npc;
    logic            w_misalign;
    logic            w_ack;
    logic            w_accept;

    npc_calc #(.XLEN(XLEN)) u_npc_calc (
        .i_pc       (r_pc),
        .i_npc_op   (npc_op_e'(bus.npc_op)),
        .i_pc_sel   (bus.pc_sel),
        .i_br_flag  (bus.br_flag),
        .i_rd1      (bus.rd1),
        .i_offset   (bus.offset),
        .o_npc      (w_npc),
        .o_misalign (w_misalign)
    );

    // ack only counts while requesting, ready only while presenting an instruction
    always_comb begin
        w_ack    = (r_state == F_REQ) && bus.irom_ack;
        w_accept = (r_state == F_VALID) && bus.inst_ready;
        w_next   = (r_state == F_BOOT)  ? F_REQ :
                   (r_state == F_REQ)   ? (w_ack ? F_VALID : F_REQ) :
                   (r_state == F_VALID) ? (!w_accept ? F_VALID : w_misalign ? F_ERR : F_REQ) :
                   F_ERR;
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) r_state <= F_BOOT;
        else         r_state <= w_next;
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_pc   <= RESET_PC;
            r_inst <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_ack)                   r_inst <= bus.irom_rdata;
            if (w_accept)                r_cnt  <= r_cnt + XLEN'(1);
            if (w_accept && !w_misalign) r_pc   <= w_npc;
            if (w_accept && w_misalign)  r_err  <= 1'b1;
        end
    end

    assign bus.irom_req   = (r_state == F_REQ);
    assign bus.irom_addr  = r_pc;
    assign bus.inst       = r_inst;
    assign bus.inst_valid = (r_state == F_VALID);
    assign bus.pc         = r_pc;
    assign bus.pc4        = r_pc + XLEN'(4);
    assign fetch_err      = r_err;
    assign inst_cnt       = r_cnt;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed self-checking bench for the miniLA fetch stage
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_err;
    logic [31:0] inst_cnt;
    logic        ack_force = 1'b0;
    int          wait_cfg = 0;
    int          wcnt = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_cnt = 0;
    logic [31:0] pcs [3];
    logic [31:0] insts [3];
    int          cycs [3];

    always #5 clk = ~clk;

    if_fetch_unit_if #(.XLEN(32)) bus ();

    if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .cpu_clk   (clk),
        .cpu_rst   (rst),
        .bus       (bus),
        .fetch_err (fetch_err),
        .inst_cnt  (inst_cnt)
    );

    // ROM model: acks after wait_cfg wait cycles (same cycle when 0), data derived from address
    assign bus.irom_ack   = ack_force | (bus.irom_req && wcnt >= wait_cfg);
    assign bus.irom_rdata = 32'h0280_0401 + bus.irom_addr;

    always_ff @(posedge clk) wcnt <= (bus.irom_req && !bus.irom_ack) ? wcnt + 1 : 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.inst_valid && n < 20) begin
            step;
            n++;
        end
        chk({tag, "_valid_to"}, {31'd0, bus.inst_valid}, 32'd1);
    endtask

    task automatic accept(input logic [1:0] op, input logic sel, input logic br,
                          input logic [31:0] r1, input logic [31:0] off,
                          input logic [31:0] want, input string tag);
        bus.npc_op     = op;
        bus.pc_sel     = sel;
        bus.br_flag    = br;
        bus.rd1        = r1;
        bus.offset     = off;
        bus.inst_ready = 1'b1;
        step;
        bus.inst_ready = 1'b0;
        exp_cnt++;
        chk({tag, "_req"}, {31'd0, bus.irom_req}, 32'd1);
        chk({tag, "_addr"}, bus.irom_addr, want);
        wait_valid(tag);
    endtask

    task automatic goto(input logic [31:0] a);
        accept(2'd2, 1'b1, 1'b0, a, 32'h0, a, "goto");
    endtask

    initial begin
        bus.inst_ready = 1'b0;
        bus.npc_op     = 2'd0;
        bus.pc_sel     = 1'b0;
        bus.br_flag    = 1'b0;
        bus.rd1        = 32'h0;
        bus.offset     = 32'h0;
        step;
        step;
        chk("rst_req", {31'd0, bus.irom_req}, 32'd0);
        chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_cnt", inst_cnt, 32'd0);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_pc", bus.pc, 32'd0);
        rst = 1'b0;
        step;
        chk("boot_req", {31'd0, bus.irom_req}, 32'd1);
        chk("boot_addr", bus.irom_addr, 32'd0);
        step;
        chk("first_valid", {31'd0, bus.inst_valid}, 32'd1);
        chk("first_inst", bus.inst, 32'h0280_0401);
        chk("first_pc", bus.pc, 32'd0);
        chk("first_pc4", bus.pc4, 32'd4);
        for (int i = 0; i < 5; i++) begin
            step;
            chk("stall_inst", bus.inst, 32'h0280_0401);
            chk("stall_pc", bus.pc, 32'd0);
            chk("stall_req", {31'd0, bus.irom_req}, 32'd0);
            chk("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
        end
        bus.inst_ready = 1'b1;
        rst = 1'b1;
        step;
        bus.inst_ready = 1'b0;
        chk("rst_valid_cnt", inst_cnt, 32'd0);
        chk("rst_valid_v", {31'd0, bus.inst_valid}, 32'd0);
        rst = 1'b0;
        step;
        step;
        wait_cfg = 2;
        bus.inst_ready = 1'b1;
        begin
            int n;
            int cyc;
            n = 0;
            cyc = 0;
            while (n < 3 && cyc < 60) begin
                if (bus.inst_valid) begin
                    pcs[n] = bus.pc;
                    insts[n] = bus.inst;
                    cycs[n] = cyc;
                    n++;
                end
                step;
                cyc++;
            end
            bus.inst_ready = 1'b0;
            chk("seq_n", n, 3);
        end
        for (int i = 0; i < 3; i++) begin
            chk("seq_pc", pcs[i], 32'(4 * i));
            chk("seq_inst", insts[i], 32'h0280_0401 + 32'(4 * i));
        end
        chk("seq_gap1", cycs[1] - cycs[0], 4);
        chk("seq_gap2", cycs[2] - cycs[1], 4);
        chk("seq_cnt", inst_cnt, 32'd3);
        exp_cnt = 3;
        wait_cfg = 0;
        wait_valid("seq_end");
        goto(32'h100);
        accept(2'd1, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFF0, 32'h0000_00F0, "brc_taken");
        goto(32'h100);
        accept(2'd1, 1'b1, 1'b0, 32'h5555_0000, 32'hFFFF_FFF0, 32'h104, "brc_not");
        accept(2'd3, 1'b1, 1'b1, 32'h5555_0000, 32'h40, 32'h108, "pc4_add");
        goto(32'h40);
        chk("jirl_pc4", bus.pc4, 32'h44);
        accept(2'd2, 1'b1, 1'b0, 32'h2000, 32'h8, 32'h2008, "jirl");
        goto(32'hFFFF_FFFC);
        chk("wrap_pc4", bus.pc4, 32'h0);
        accept(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, "wrap");
        chk("mid_cnt", inst_cnt, exp_cnt);
        goto(32'h80);
        bus.npc_op     = 2'd2;
        bus.pc_sel     = 1'b1;
        bus.rd1        = 32'h2002;
        bus.offset     = 32'h0;
        bus.inst_ready = 1'b1;
        step;
        bus.inst_ready = 1'b0;
        exp_cnt++;
        chk("err_flag", {31'd0, fetch_err}, 32'd1);
        chk("err_req", {31'd0, bus.irom_req}, 32'd0);
        chk("err_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("err_pc", bus.pc, 32'h80);
        chk("err_cnt", inst_cnt, exp_cnt);
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step;
            chk("err_hold", {30'd0, fetch_err, bus.irom_req}, 32'd2);
        end
        bus.inst_ready = 1'b0;
        rst = 1'b1;
        step;
        chk("err_rst_flag", {31'd0, fetch_err}, 32'd0);
        chk("err_rst_pc", bus.pc, 32'd0);
        rst = 1'b0;
        step;
        step;
        chk("re_inst", bus.inst, 32'h0280_0401);
        wait_cfg = 5;
        bus.npc_op = 2'd0;
        bus.inst_ready = 1'b1;
        step;
        bus.inst_ready = 1'b0;
        chk("pend_addr", bus.irom_addr, 32'd4);
        rst = 1'b1;
        ack_force = 1'b1;
        step;
        chk("rstreq_inst", bus.inst, 32'd0);
        chk("rstreq_req", {31'd0, bus.irom_req}, 32'd0);
        chk("rstreq_valid", {31'd0, bus.inst_valid}, 32'd0);
        rst = 1'b0;
        ack_force = 1'b0;
        step;
        chk("restart_req", {31'd0, bus.irom_req}, 32'd1);
        chk("restart_addr", bus.irom_addr, 32'd0);
        chk("restart_inst", bus.inst, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
